// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier: one partial-product step per clock,
// N iterations per operation, with a one-cycle done pulse and a held product register.
module shift_add_mult #(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic [2*N-1:0] P,
  output logic           busy,
  output logic           done
);

  localparam int unsigned PW = 2 * N;
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   p_q, p_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Upper-half add with carry-out kept as the (N+1)th bit so the shift loses nothing.
  logic [N:0]      addend_c;
  logic [N:0]      sum_c;
  logic [PW-1:0]   acc_step_c;

  always_comb begin
    addend_c   = acc_q[0] ? {1'b0, mcand_q} : '0;
    sum_c      = {1'b0, acc_q[PW-1:N]} + addend_c;
    acc_step_c = {sum_c, acc_q[N-1:1]};
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          mcand_d = A;
          acc_d   = {{N{1'b0}}, B};
          cnt_d   = CW'(N);
        end
      end

      ST_RUN: begin
        acc_d = acc_step_c;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
          p_d     = acc_step_c;
        end
      end

      ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          mcand_d = A;
          acc_d   = {{N{1'b0}}, B};
          cnt_d   = CW'(N);
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign P    = p_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed bench for shift_add_mult (N=8): hand-computed products, latency,
// start-ignore during RUN, reset abort and back-to-back operation.
module tb_shift_add_mult;

  localparam int unsigned N = 8;

  logic            clk;
  logic            rst;
  logic            start;
  logic [N-1:0]    A;
  logic [N-1:0]    B;
  logic [2*N-1:0]  P;
  logic            busy;
  logic            done;

  int n_vec;
  int n_miss;

  shift_add_mult #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .P     (P),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Launch one multiply and follow it to its done pulse, checking latency and P hold.
  task automatic do_mult(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [31:0] exp_p, input string tag);
    logic [2*N-1:0] p_prev;
    int cycles;
    p_prev = P;
    A = a;
    B = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_start"}, 32'(busy), 32'd1);
    cycles = 1;
    while (!done && cycles < 20) begin
      chk({tag, "_p_hold_run"}, 32'(P), 32'(p_prev));
      tick();
      cycles++;
    end
    chk({tag, "_latency"}, 32'(cycles), 32'd9);
    chk({tag, "_p"}, 32'(P), exp_p);
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int pulses;
    logic [2*N-1:0] p_at_done;
    n_vec  = 0;
    n_miss = 0;
    rst    = 1'b1;
    start  = 1'b0;
    A      = '0;
    B      = '0;

    tick();
    tick();
    chk("rst_p",    32'(P),    32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // Start accepted on the very first edge with rst low.
    rst = 1'b0;
    do_mult(8'd13, 8'd11, 32'd143, "m13x11");
    for (int i = 0; i < 10; i++) tick();
    chk("m13x11_p_held", 32'(P), 32'd143);
    chk("m13x11_idle_done", 32'(done), 32'd0);

    do_mult(8'd255, 8'd255, 32'd65025, "m255x255");
    do_mult(8'd0,   8'd200, 32'd0,     "m0x200");
    do_mult(8'd200, 8'd0,   32'd0,     "m200x0");
    do_mult(8'd1,   8'd1,   32'd1,     "m1x1");
    do_mult(8'd128, 8'd2,   32'd256,   "m128x2");
    do_mult(8'd170, 8'd85,  32'd14450, "m170x85");

    // Start pulse with new operands during RUN must be ignored.
    A = 8'd6;
    B = 8'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    A = 8'd100;
    B = 8'd100;
    start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0;
    p_at_done = '0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        pulses++;
        p_at_done = P;
      end
      tick();
    end
    chk("ign_pulses", 32'(pulses), 32'd1);
    chk("ign_p", 32'(p_at_done), 32'd42);

    // Reset in the middle of an operation aborts it and clears P.
    A = 8'd9;
    B = 8'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_p",    32'(P),    32'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    chk("abort_p_still0", 32'(P), 32'd0);
    do_mult(8'd3, 8'd5, 32'd15, "m3x5");

    // Start held high: DONE goes straight back to RUN, one done every 9 cycles.
    A = 8'd12;
    B = 8'd12;
    start = 1'b1;
    tick();
    for (int i = 1; i <= 26; i++) begin
      tick();
      chk("b2b_done", 32'(done), ((i % 9) == 8) ? 32'd1 : 32'd0);
      chk("b2b_busy", 32'(busy), ((i % 9) == 8) ? 32'd0 : 32'd1);
      if (done) chk("b2b_p", 32'(P), 32'd144);
    end
    start = 1'b0;
    tick();
    chk("b2b_end_busy", 32'(busy), 32'd0);
    chk("b2b_end_done", 32'(done), 32'd0);
    chk("b2b_end_p",    32'(P),    32'd144);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/shift_add_mult.md
SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 Parameter: N, default 8, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request to begin a multiply; sampled on the rising edge of clk.
REQ-005 Port: A  input  N  multiplicand, unsigned; sampled only on the edge that accepts start.
REQ-006 Port: B  input  N  multiplier, unsigned; sampled only on the edge that accepts start.
REQ-007 Port: P  output  2N  registered unsigned product A*B of the last completed operation.
REQ-008 Port: busy  output  1  high while an operation is in progress (state RUN).
REQ-009 Port: done  output  1  single-cycle completion pulse; P is valid and newly updated while done=1.
REQ-010 The block is a single clock domain: one clock (clk), with synchronous, active-high reset (rst).

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-012 IDLE: busy=0, done=0; start=1 -> RUN, latching mcand<=A, acc<={N'b0,B} and cnt<=N.
REQ-013 RUN: busy=1, done=0; on each edge the block SHALL do one iteration and then decrement cnt.
REQ-014 Iteration, add step: if acc[0]=1, {c,s} = acc[2N-1:N] + mcand as an N-bit add with carry-out c; otherwise {c,s} = {0, acc[2N-1:N]}.
REQ-015 Iteration, shift step: acc <= {c, s, acc[N-1:1]}, a logical right shift by one that preserves the carry; no bit SHALL be lost.
REQ-016 The iteration on which cnt goes 1->0 SHALL move RUN -> DONE and load P with the final acc value in the same edge.
REQ-017 DONE: busy=0, done=1 for exactly one cycle; the next edge -> IDLE, unless start=1, in which case -> RUN with a new operation latched as in REQ-012.
REQ-018 Latency: start accepted at edge E0, iterations at edges E1..EN, done=1 in the cycle after EN; total N+1 cycles from the start edge to the done cycle.
REQ-019 start SHALL be ignored while in RUN; A and B changes during RUN SHALL NOT affect the result.
REQ-020 P SHALL hold its value from the completion edge until the next completion; it does not change during RUN.
REQ-021 Result SHALL be exact for all operand pairs; max product (2^N-1)^2 fits in 2N bits without overflow.
REQ-022 Operands of zero SHALL still take the full N iterations; there is no early termination.
REQ-023 The iteration counter SHALL be ceil(log2(N+1)) bits wide and SHALL never wrap below 0.

Reset
REQ-024 When rst=1 on an edge: state<=IDLE, busy=0, done=0, P=0, acc=0, mcand=0, cnt=0.
REQ-025 Reset SHALL take priority over start and over any in-progress iteration; an operation aborted by reset produces no done pulse and P stays 0.
REQ-026 On the first edge with rst=0, start=1 SHALL be accepted normally.

Verification
REQ-027 N=8, A=13, B=11, start pulsed for 1 cycle -> busy for 8 cycles, then done=1 for 1 cycle with P=143; P still 143 ten cycles later.
REQ-028 N=8, A=255, B=255 -> P=65025 (0xFE01) at done; checks carry preservation on the upper-half adds.
REQ-029 N=8, A=0, B=200, then A=200, B=0 -> each gives done after exactly 9 cycles (N+1) with P=0.
REQ-030 N=8, start A=6, B=7; pulse start with A=100, B=100 during RUN -> ignored, P=42, exactly one done pulse.
REQ-031 N=8, start A=9, B=9; assert rst at iteration 4 -> next cycle busy=0, done=0, P=0, and no done pulse follows; then A=3, B=5 -> P=15.
REQ-032 N=8, start held high continuously with A=12, B=12 -> done pulse every 9 cycles, P=144; the DONE->RUN transition is taken with no IDLE cycle between operations.
